// File: rtl/jserial_alu_pkg.sv
// Shared encodings and one-bit gate helpers for the bit-serial ALU.
// The cell and the zero flag are built from the gate helpers below.
package jserial_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic jnot(input logic x);
    return ~x;
  endfunction

  function automatic logic jand(input logic x, input logic y);
    return x & y;
  endfunction

  function automatic logic jor(input logic x, input logic y);
    return x | y;
  endfunction

  function automatic logic jxor(input logic x, input logic y);
    return x ^ y;
  endfunction

endpackage

// File: rtl/jserial_cell.sv
// Combinational one-bit cell shared by all modes of the serial ALU.
module jserial_cell
  import jserial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic carry,
  input  logic eq,
  input  logic al,
  input  op_t  op,
  output logic r,
  output logic carry_nx,
  output logic eq_nx,
  output logic al_nx
);

  logic c;

  assign c        = jxor(a, b);
  assign carry_nx = jor(jand(carry, c), jand(a, b));
  assign eq_nx    = jand(eq, jnot(c));
  // A wins at the first differing bit (MSB first) where A holds the 1.
  assign al_nx    = jor(al, jand(eq, jand(a, c)));

  always_comb begin
    r = 1'b0;
    case (op)
      OP_ADD:  r = jxor(c, carry);
      OP_CMP:  r = c;
      OP_AND:  r = jand(a, b);
      OP_OR:   r = jor(a, b);
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/jserial_alu.sv
// Bit-serial N-bit ALU: ADD/CMP/AND/OR through one shared cell, with a
// start/busy/done handshake and result registers held until the next start.
module jserial_alu
  import jserial_alu_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         wstart,
  input  logic [1:0]   bop,
  input  logic [N-1:0] bas,
  input  logic [N-1:0] bbs,
  input  logic         wci,
  output logic         wbusy,
  output logic         wdone,
  output logic [N-1:0] bos,
  output logic         wco,
  output logic         weq,
  output logic         wal,
  output logic         wz
);

  state_t        state;
  op_t           op_q;
  logic [N-1:0]  a_sh, b_sh, r_sh, r_nx;
  logic [CW-1:0] cnt;
  logic          carry, eq, al, armed;
  logic          msb_first, a_bit, b_bit;
  logic          r_bit, carry_nx, eq_nx, al_nx;

  assign msb_first = (op_q == OP_CMP);
  assign a_bit     = msb_first ? a_sh[N-1] : a_sh[0];
  assign b_bit     = msb_first ? b_sh[N-1] : b_sh[0];
  assign wz        = jnot(|bos);

  jserial_cell u_cell (
    .a        (a_bit),
    .b        (b_bit),
    .carry    (carry),
    .eq       (eq),
    .al       (al),
    .op       (op_q),
    .r        (r_bit),
    .carry_nx (carry_nx),
    .eq_nx    (eq_nx),
    .al_nx    (al_nx)
  );

  always_comb begin
    r_nx = r_sh;
    if (msb_first) r_nx = {r_sh[N-2:0], r_bit};
    else           r_nx = {r_bit, r_sh[N-1:1]};
  end

  // The first RUN cycle only arms the datapath, so done lands N+1 edges after accept.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= ST_IDLE;
      op_q  <= OP_ADD;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      eq    <= 1'b0;
      al    <= 1'b0;
      armed <= 1'b0;
      wbusy <= 1'b0;
      wdone <= 1'b0;
      bos   <= '0;
      wco   <= 1'b0;
      weq   <= 1'b0;
      wal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          wdone <= 1'b0;
          if (wstart) begin
            a_sh  <= bas;
            b_sh  <= bbs;
            op_q  <= op_t'(bop);
            carry <= wci;
            eq    <= 1'b1;
            al    <= 1'b0;
            cnt   <= '0;
            armed <= 1'b0;
            wbusy <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!armed) begin
            armed <= 1'b1;
          end else begin
            if (msb_first) begin
              a_sh <= {a_sh[N-2:0], 1'b0};
              b_sh <= {b_sh[N-2:0], 1'b0};
            end else begin
              a_sh <= {1'b0, a_sh[N-1:1]};
              b_sh <= {1'b0, b_sh[N-1:1]};
            end
            r_sh  <= r_nx;
            carry <= carry_nx;
            eq    <= eq_nx;
            al    <= al_nx;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              state <= ST_DONE;
              wbusy <= 1'b0;
              wdone <= 1'b1;
              bos   <= r_nx;
              wco   <= (op_q == OP_ADD) & carry_nx;
              weq   <= (op_q == OP_CMP) & eq_nx;
              wal   <= (op_q == OP_CMP) & al_nx;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jserial_alu.sv
// Scoreboard bench for jserial_alu: directed N=8 scenarios plus random
// ADD/CMP on N=3 and N=16 builds against a reference model.
module tb_jserial_alu;

  typedef struct packed {
    logic [15:0] r;
    logic        co;
    logic        eq;
    logic        al;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, ci8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00, bos8;
  logic        busy8, done8, co8, eq8, al8, z8;

  logic        start3 = 1'b0, ci3 = 1'b0;
  logic [1:0]  op3 = 2'b00;
  logic [2:0]  a3 = 3'h0, b3 = 3'h0, bos3;
  logic        busy3, done3, co3, eq3, al3, z3;

  logic        start16 = 1'b0, ci16 = 1'b0;
  logic [1:0]  op16 = 2'b00;
  logic [15:0] a16 = 16'h0, b16 = 16'h0, bos16;
  logic        busy16, done16, co16, eq16, al16, z16;

  int   checks = 0;
  int   errors = 0;
  exp_t q8[$], q3[$], q16[$];

  jserial_alu #(.N(8)) u8 (
    .wclk(clk), .wrst(rst), .wstart(start8), .bop(op8), .bas(a8), .bbs(b8), .wci(ci8),
    .wbusy(busy8), .wdone(done8), .bos(bos8), .wco(co8), .weq(eq8), .wal(al8), .wz(z8));

  jserial_alu #(.N(3)) u3 (
    .wclk(clk), .wrst(rst), .wstart(start3), .bop(op3), .bas(a3), .bbs(b3), .wci(ci3),
    .wbusy(busy3), .wdone(done3), .bos(bos3), .wco(co3), .weq(eq3), .wal(al3), .wz(z3));

  jserial_alu #(.N(16)) u16 (
    .wclk(clk), .wrst(rst), .wstart(start16), .bop(op16), .bas(a16), .bbs(b16), .wci(ci16),
    .wbusy(busy16), .wdone(done16), .bos(bos16), .wco(co16), .weq(eq16), .wal(al16), .wz(z16));

  function automatic exp_t ref_model(input int w, input logic [1:0] op,
                                     input logic [15:0] a_in, input logic [15:0] b_in,
                                     input logic ci);
    exp_t        e;
    logic [15:0] m, a, b;
    logic [16:0] s;
    m = 16'((32'd1 << w) - 32'd1);
    a = a_in & m;
    b = b_in & m;
    e = '0;
    case (op)
      2'b00: begin
        s    = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        e.r  = s[15:0] & m;
        e.co = s[w];
      end
      2'b01: begin
        e.r  = a ^ b;
        e.eq = (a == b);
        e.al = (a > b);
      end
      2'b10:   e.r = a & b;
      default: e.r = a | b;
    endcase
    e.z = (e.r == 16'd0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one accept edge on the N=8 DUT, then scrambles the operand ports.
  task automatic start8_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic ci);
    op8 = op; a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    q8.push_back(ref_model(8, op, {8'h00, a}, {8'h00, b}, ci));
    tick;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom); ci8 = 1'($urandom);
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!done8 && cyc < 40);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({busy8, done8, bos8, co8, eq8, al8, z8} !== {2'b00, 8'h00, 4'b0001}) begin
      errors++;
      $display("FAIL reset8 got %b exp %b", {busy8, done8, bos8, co8, eq8, al8, z8},
               {2'b00, 8'h00, 4'b0001});
    end
    checks++;
    if ({busy16, done16, bos16, z16} !== {2'b00, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset16 got %b", {busy16, done16, bos16, z16});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add_overflow;
    exp_t e;
    int   cyc;
    start8_op(2'b00, 8'hFF, 8'h01, 1'b0);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL add_busy got %b exp 1", busy8);
    end
    wait8(cyc);
    e = q8.pop_front();
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL add_latency got %0d exp 9", cyc);
    end
    checks++;
    if ({bos8, co8, eq8, al8, z8, busy8} !== {e.r[7:0], e.co, e.eq, e.al, e.z, 1'b0}) begin
      errors++;
      $display("FAIL add_ff_01 got %h/%b exp %h/%b", bos8, {co8, eq8, al8, z8, busy8},
               e.r[7:0], {e.co, e.eq, e.al, e.z, 1'b0});
    end
    tick;
    checks++;
    if ({done8, bos8, co8, z8} !== {1'b0, e.r[7:0], e.co, e.z}) begin
      errors++;
      $display("FAIL add_hold got %b exp %b", {done8, bos8, co8, z8}, {1'b0, e.r[7:0], e.co, e.z});
    end
  endtask

  task automatic test_cmp;
    exp_t e;
    int   cyc;
    logic [7:0] av[3] = '{8'h5A, 8'h80, 8'h7F};
    logic [7:0] bv[3] = '{8'h5A, 8'h7F, 8'h80};
    for (int i = 0; i < 3; i++) begin
      start8_op(2'b01, av[i], bv[i], 1'b1);
      wait8(cyc);
      e = q8.pop_front();
      checks++;
      if (cyc !== 9 || {bos8, co8, eq8, al8, z8} !== {e.r[7:0], e.co, e.eq, e.al, e.z}) begin
        errors++;
        $display("FAIL cmp_%0d got %h/%b lat %0d exp %h/%b lat 9", i, bos8,
                 {co8, eq8, al8, z8}, cyc, e.r[7:0], {e.co, e.eq, e.al, e.z});
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc;
    start8_op(2'b00, 8'h3C, 8'h0F, 1'b1);
    wait8(cyc);
    e = q8.pop_front();
    checks++;
    if ({bos8, co8, z8} !== {e.r[7:0], e.co, e.z}) begin
      errors++;
      $display("FAIL b2b_add got %h/%b exp %h/%b", bos8, {co8, z8}, e.r[7:0], {e.co, e.z});
    end
    start8_op(2'b10, 8'hF0, 8'h3C, 1'b0);
    wait8(cyc);
    e = q8.pop_front();
    checks++;
    if (cyc !== 9 || {bos8, co8, eq8, al8, z8} !== {e.r[7:0], e.co, e.eq, e.al, e.z}) begin
      errors++;
      $display("FAIL b2b_and got %h lat %0d exp %h lat 9", bos8, cyc, e.r[7:0]);
    end
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int   dones = 0;
    int   first = 0;
    logic [11:0] seen = '0;
    start8_op(2'b00, 8'h55, 8'h2B, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      start8 = (k >= 2 && k <= 4);
      if (start8) begin
        op8 = 2'b11; a8 = 8'hAA; b8 = 8'h11;
      end
      tick;
      if (done8) begin
        dones++;
        if (first == 0) first = k;
        seen = {bos8, co8, eq8, al8, z8};
      end
    end
    e = q8.pop_front();
    checks++;
    if (dones !== 1 || first !== 9 || seen !== {e.r[7:0], e.co, e.eq, e.al, e.z}) begin
      errors++;
      $display("FAIL start_ignored got dones %0d at %0d val %h exp 1 at 9 val %h", dones,
               first, seen, {e.r[7:0], e.co, e.eq, e.al, e.z});
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   cyc;
    int   dones = 0;
    start8_op(2'b01, 8'h80, 8'h7F, 1'b0);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q8.delete();
    checks++;
    if ({busy8, done8, bos8, z8} !== {2'b00, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL abort_state got %b exp %b", {busy8, done8, bos8, z8}, {2'b00, 8'h00, 1'b1});
    end
    for (int k = 0; k < 15; k++) begin
      tick;
      if (done8) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses exp 0", dones);
    end
    start8_op(2'b11, 8'h0A, 8'h50, 1'b0);
    wait8(cyc);
    e = q8.pop_front();
    checks++;
    if (cyc !== 9 || {bos8, z8} !== {e.r[7:0], e.z}) begin
      errors++;
      $display("FAIL abort_then_or got %h lat %0d exp %h lat 9", bos8, cyc, e.r[7:0]);
    end
  endtask

  task automatic test_random_widths;
    exp_t        e;
    int          cyc;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        ci;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = (i == 1) ? a : 16'($urandom);
      ci = 1'($urandom);
      if (i == 0) begin
        op = 2'b00; a = 16'hFFFF; b = 16'h0000; ci = 1'b1;
      end
      op3 = op; a3 = a[2:0]; b3 = b[2:0]; ci3 = ci; start3 = 1'b1;
      q3.push_back(ref_model(3, op, a, b, ci));
      tick;
      start3 = 1'b0;
      cyc = 0;
      do begin
        tick;
        cyc++;
      end while (!done3 && cyc < 40);
      e = q3.pop_front();
      checks++;
      if (cyc !== 4 || {bos3, co3, eq3, al3, z3, busy3} !== {e.r[2:0], e.co, e.eq, e.al, e.z, 1'b0}) begin
        errors++;
        $display("FAIL rand3_%0d op %0d a %h b %h got %h/%b lat %0d exp %h/%b", i, op, a[2:0],
                 b[2:0], bos3, {co3, eq3, al3, z3}, cyc, e.r[2:0], {e.co, e.eq, e.al, e.z});
      end
      op16 = op; a16 = a; b16 = b; ci16 = ci; start16 = 1'b1;
      q16.push_back(ref_model(16, op, a, b, ci));
      tick;
      start16 = 1'b0;
      a16 = 16'($urandom);
      cyc = 0;
      do begin
        tick;
        cyc++;
      end while (!done16 && cyc < 40);
      e = q16.pop_front();
      checks++;
      if (cyc !== 17 || {bos16, co16, eq16, al16, z16, busy16} !== {e.r, e.co, e.eq, e.al, e.z, 1'b0}) begin
        errors++;
        $display("FAIL rand16_%0d op %0d a %h b %h got %h/%b lat %0d exp %h/%b", i, op, a, b,
                 bos16, {co16, eq16, al16, z16}, cyc, e.r, {e.co, e.eq, e.al, e.z});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_cmp();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_random_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
